// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller and ID stage.
// Opcodes, Funct codes, state/class enums and mux encodings.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_ALUWB  = 3'd3,
        S_ADDR   = 3'd4,
        S_MEM    = 3'd5,
        S_MEMWB  = 3'd6,
        S_JUMP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_RTYPE   = 3'd0,
        CL_ITYPE   = 3'd1,
        CL_LOAD    = 3'd2,
        CL_STORE   = 3'd3,
        CL_JUMP    = 3'd4,
        CL_JR      = 3'd5,
        CL_BRANCH  = 3'd6,
        CL_ILLEGAL = 3'd7
    } ins_class_t;

    localparam logic [1:0] PCSRC_PC4  = 2'd0;
    localparam logic [1:0] PCSRC_BR   = 2'd1;
    localparam logic [1:0] PCSRC_JMP  = 2'd2;
    localparam logic [1:0] PCSRC_JR   = 2'd3;

    localparam logic [1:0] REGDST_RT  = 2'd0;
    localparam logic [1:0] REGDST_RD  = 2'd1;
    localparam logic [1:0] REGDST_R31 = 2'd2;

    localparam logic [1:0] WB_ALU     = 2'd0;
    localparam logic [1:0] WB_MEM     = 2'd1;
    localparam logic [1:0] WB_PC4     = 2'd2;

    localparam logic [1:0] SRCB_RD2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

endpackage

// File: rtl/mc_ins_class.sv
// Instruction classifier: Opcode/Funct to execution class.
// Purely combinational, shared by decode and output logic.
module mc_ins_class
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    output logic [2:0] Cls
);

    ins_class_t c;

    // Map the opcode (and Funct for JR) onto a class.
    always_comb begin
        c = CL_ILLEGAL;
        unique case (Opcode)
            OP_RTYPE:
                c = (Funct == FN_JR) ? CL_JR : CL_RTYPE;
            OP_J, OP_JAL:
                c = CL_JUMP;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                c = CL_BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                c = CL_ITYPE;
            OP_LW:
                c = CL_LOAD;
            OP_SW:
                c = CL_STORE;
            default:
                c = CL_ILLEGAL;
        endcase
    end

    assign Cls = c;

endmodule

// File: rtl/mc_control.sv
// Multicycle control sequencer for the single-port MIPS datapath.
// Owns the memory port arbitration and the retired-instruction count.
module mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [5:0]          Opcode,
    input  logic [5:0]          Funct,
    input  logic                MemAck,
    input  logic                BranchTaken,
    output logic                MemReq,
    output logic                MemWe,
    output logic                IorD,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [1:0]          PCSrc,
    output logic                RegWrite,
    output logic [1:0]          RegDst,
    output logic [1:0]          WBSel,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          State,
    output logic [RETIRE_W-1:0] Retired,
    output logic                Illegal
);

    state_t     state;
    state_t     state_nx;
    logic [2:0] cls_raw;
    ins_class_t cls;
    logic       retire;
    logic       is_jal;

    mc_ins_class u_cls (
        .Opcode (Opcode),
        .Funct  (Funct),
        .Cls    (cls_raw)
    );

    assign cls    = ins_class_t'(cls_raw);
    assign is_jal = (cls == CL_JUMP) && (Opcode == OP_JAL);
    assign State  = state;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_FETCH;
        else     state <= state_nx;
    end

    // Retired-instruction counter; wraps naturally at full scale.
    always_ff @(posedge CLK) begin
        if (RST)         Retired <= '0;
        else if (retire) Retired <= Retired + RETIRE_W'(1);
    end

    // Next-state and datapath control, all outputs default to 0.
    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        MemReq   = 1'b0;
        MemWe    = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = PCSRC_PC4;
        RegWrite = 1'b0;
        RegDst   = REGDST_RT;
        WBSel    = WB_ALU;
        ALUSrcB  = SRCB_RD2;
        Illegal  = 1'b0;
        unique case (state)
            S_FETCH: begin
                MemReq = 1'b1;
                if (MemAck) begin
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                    PCSrc    = PCSRC_PC4;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (cls)
                    CL_RTYPE, CL_ITYPE:          state_nx = S_EXEC;
                    CL_JUMP, CL_JR, CL_BRANCH:   state_nx = S_JUMP;
                    CL_LOAD, CL_STORE:           state_nx = S_ADDR;
                    default: begin
                        Illegal  = 1'b1;
                        state_nx = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                ALUSrcB  = (cls == CL_RTYPE) ? SRCB_RD2 : SRCB_IMM;
                state_nx = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                WBSel    = WB_ALU;
                RegDst   = (cls == CL_RTYPE) ? REGDST_RD : REGDST_RT;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_ADDR: begin
                ALUSrcB  = SRCB_IMM;
                state_nx = S_MEM;
            end
            S_MEM: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
                MemWe  = (cls == CL_STORE);
                if (MemAck) begin
                    if (cls == CL_STORE) begin
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_MEMWB;
                    end
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                WBSel    = WB_MEM;
                RegDst   = REGDST_RT;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_JUMP: begin
                retire   = 1'b1;
                state_nx = S_FETCH;
                if (cls == CL_JR) begin
                    PCWrite = 1'b1;
                    PCSrc   = PCSRC_JR;
                end else if (cls == CL_BRANCH) begin
                    PCWrite = BranchTaken;
                    PCSrc   = PCSRC_BR;
                end else begin
                    PCWrite = 1'b1;
                    PCSrc   = PCSRC_JMP;
                    if (is_jal) begin
                        RegWrite = 1'b1;
                        RegDst   = REGDST_R31;
                        WBSel    = WB_PC4;
                    end
                end
            end
            default: state_nx = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control.
// Per-cycle expected output vectors are queued and popped as cycles run.
module tb_mc_control;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] Opcode = 6'h00;
    logic [5:0] Funct = 6'h00;
    logic       MemAck = 1'b0;
    logic       BranchTaken = 1'b0;

    logic        MemReq, MemWe, IorD, IRWrite, PCWrite, RegWrite, Illegal;
    logic [1:0]  PCSrc, RegDst, WBSel, ALUSrcB;
    logic [2:0]  State;
    logic [31:0] Retired;

    logic        s_MemReq, s_MemWe, s_IorD, s_IRWrite, s_PCWrite;
    logic        s_RegWrite, s_Illegal;
    logic [1:0]  s_PCSrc, s_RegDst, s_WBSel, s_ALUSrcB;
    logic [2:0]  s_State;
    logic [2:0]  s_Retired;

    always #5 CLK = ~CLK;

    mc_control #(.RETIRE_W(32)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct),
        .MemAck(MemAck), .BranchTaken(BranchTaken),
        .MemReq(MemReq), .MemWe(MemWe), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .RegDst(RegDst), .WBSel(WBSel),
        .ALUSrcB(ALUSrcB), .State(State), .Retired(Retired),
        .Illegal(Illegal)
    );

    mc_control #(.RETIRE_W(3)) u_small (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct),
        .MemAck(MemAck), .BranchTaken(BranchTaken),
        .MemReq(s_MemReq), .MemWe(s_MemWe), .IorD(s_IorD),
        .IRWrite(s_IRWrite), .PCWrite(s_PCWrite), .PCSrc(s_PCSrc),
        .RegWrite(s_RegWrite), .RegDst(s_RegDst), .WBSel(s_WBSel),
        .ALUSrcB(s_ALUSrcB), .State(s_State), .Retired(s_Retired),
        .Illegal(s_Illegal)
    );

    typedef struct packed {
        logic        rst;
        logic        ack;
        logic        br;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [17:0] exp;
    } step_t;

    step_t sb[$];
    step_t s;
    int    vectors = 0;
    int    miscompares = 0;
    logic [31:0] exp_ret = 0;

    logic [17:0] V_FWAIT, V_FACK, V_DEC, V_EXR, V_EXI, V_WBR, V_WBI;
    logic [17:0] V_ADDR, V_MLW, V_MSW, V_MWB;
    logic [17:0] V_BR0, V_BR1, V_JAL, V_J, V_JR, V_ILL;

    function automatic logic [17:0] mk(
        input logic [2:0] st, input logic mr, input logic mw,
        input logic io, input logic irw, input logic pcw,
        input logic [1:0] pcs, input logic rw, input logic [1:0] rd,
        input logic [1:0] wb, input logic [1:0] asb, input logic ill);
        return {st, mr, mw, io, irw, pcw, pcs, rw, rd, wb, asb, ill};
    endfunction

    function automatic logic [17:0] obs();
        return {State, MemReq, MemWe, IorD, IRWrite, PCWrite, PCSrc,
                RegWrite, RegDst, WBSel, ALUSrcB, Illegal};
    endfunction

    task automatic push(input logic rst, input logic ack, input logic br,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic [17:0] e);
        sb.push_back({rst, ack, br, op, fn, e});
    endtask

    task automatic test_reset();
        int n;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        vectors++;
        if (State !== 3'd0 || Retired !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_hold: State=%0d Retired=%0d want 0/0",
                     State, Retired);
        end
        push(0, 0, 0, 6'h00, 6'h20, V_FWAIT);
        n = 0;
        while (sb.size() != 0) begin
            s = sb.pop_front();
            RST = s.rst; MemAck = s.ack; BranchTaken = s.br;
            Opcode = s.op; Funct = s.fn;
            #1;
            vectors++;
            if (obs() !== s.exp) begin
                miscompares++;
                $display("FAIL reset_out cyc%0d: got %h want %h",
                         n, obs(), s.exp);
            end
            n++;
            @(negedge CLK);
        end
        MemAck = 0; BranchTaken = 0;
    endtask

    task automatic test_alu();
        int n;
        push(0, 1, 0, 6'h00, 6'h20, V_FACK);
        push(0, 0, 0, 6'h00, 6'h20, V_DEC);
        push(0, 0, 0, 6'h00, 6'h20, V_EXR);
        push(0, 0, 0, 6'h00, 6'h20, V_WBR);
        push(0, 1, 0, 6'h08, 6'h00, V_FACK);
        push(0, 0, 0, 6'h08, 6'h00, V_DEC);
        push(0, 0, 0, 6'h08, 6'h00, V_EXI);
        push(0, 0, 0, 6'h08, 6'h00, V_WBI);
        exp_ret = exp_ret + 2;
        n = 0;
        while (sb.size() != 0) begin
            s = sb.pop_front();
            RST = s.rst; MemAck = s.ack; BranchTaken = s.br;
            Opcode = s.op; Funct = s.fn;
            #1;
            vectors++;
            if (obs() !== s.exp) begin
                miscompares++;
                $display("FAIL alu cyc%0d: got %h want %h",
                         n, obs(), s.exp);
            end
            n++;
            @(negedge CLK);
        end
        MemAck = 0; BranchTaken = 0;
        vectors++;
        if (Retired !== exp_ret || s_Retired !== exp_ret[2:0]) begin
            miscompares++;
            $display("FAIL alu_retired: got %0d/%0d want %0d",
                     Retired, s_Retired, exp_ret);
        end
    endtask

    task automatic test_lw_wait();
        int n;
        repeat (3) push(0, 0, 0, 6'h23, 6'h00, V_FWAIT);
        push(0, 1, 0, 6'h23, 6'h00, V_FACK);
        push(0, 0, 0, 6'h23, 6'h00, V_DEC);
        push(0, 0, 0, 6'h23, 6'h00, V_ADDR);
        repeat (3) push(0, 0, 0, 6'h23, 6'h00, V_MLW);
        push(0, 1, 0, 6'h23, 6'h00, V_MLW);
        push(0, 0, 0, 6'h23, 6'h00, V_MWB);
        exp_ret = exp_ret + 1;
        n = 0;
        while (sb.size() != 0) begin
            s = sb.pop_front();
            RST = s.rst; MemAck = s.ack; BranchTaken = s.br;
            Opcode = s.op; Funct = s.fn;
            #1;
            vectors++;
            if (obs() !== s.exp) begin
                miscompares++;
                $display("FAIL lw cyc%0d: got %h want %h",
                         n, obs(), s.exp);
            end
            n++;
            @(negedge CLK);
        end
        MemAck = 0; BranchTaken = 0;
        vectors++;
        if (n != 11 || State !== 3'd0 || Retired !== exp_ret) begin
            miscompares++;
            $display("FAIL lw_end: cycles=%0d State=%0d Retired=%0d want 11/0/%0d",
                     n, State, Retired, exp_ret);
        end
    endtask

    task automatic test_sw();
        int n;
        push(0, 1, 0, 6'h2B, 6'h00, V_FACK);
        push(0, 0, 0, 6'h2B, 6'h00, V_DEC);
        push(0, 0, 0, 6'h2B, 6'h00, V_ADDR);
        push(0, 1, 0, 6'h2B, 6'h00, V_MSW);
        push(0, 0, 0, 6'h2B, 6'h00, V_FWAIT);
        exp_ret = exp_ret + 1;
        n = 0;
        while (sb.size() != 0) begin
            s = sb.pop_front();
            RST = s.rst; MemAck = s.ack; BranchTaken = s.br;
            Opcode = s.op; Funct = s.fn;
            #1;
            vectors++;
            if (obs() !== s.exp) begin
                miscompares++;
                $display("FAIL sw cyc%0d: got %h want %h",
                         n, obs(), s.exp);
            end
            n++;
            @(negedge CLK);
        end
        MemAck = 0; BranchTaken = 0;
        vectors++;
        if (Retired !== exp_ret || s_Retired !== exp_ret[2:0]) begin
            miscompares++;
            $display("FAIL sw_retired: got %0d/%0d want %0d",
                     Retired, s_Retired, exp_ret);
        end
    endtask

    task automatic test_branch_jal();
        int n;
        push(0, 1, 0, 6'h04, 6'h00, V_FACK);
        push(0, 0, 0, 6'h04, 6'h00, V_DEC);
        push(0, 0, 0, 6'h04, 6'h00, V_BR0);
        push(0, 1, 0, 6'h04, 6'h00, V_FACK);
        push(0, 0, 0, 6'h04, 6'h00, V_DEC);
        push(0, 0, 1, 6'h04, 6'h00, V_BR1);
        push(0, 1, 0, 6'h03, 6'h00, V_FACK);
        push(0, 0, 0, 6'h03, 6'h00, V_DEC);
        push(0, 0, 0, 6'h03, 6'h00, V_JAL);
        push(0, 1, 0, 6'h02, 6'h00, V_FACK);
        push(0, 0, 0, 6'h02, 6'h00, V_DEC);
        push(0, 0, 0, 6'h02, 6'h00, V_J);
        push(0, 1, 0, 6'h00, 6'h08, V_FACK);
        push(0, 0, 0, 6'h00, 6'h08, V_DEC);
        push(0, 0, 0, 6'h00, 6'h08, V_JR);
        exp_ret = exp_ret + 5;
        n = 0;
        while (sb.size() != 0) begin
            s = sb.pop_front();
            RST = s.rst; MemAck = s.ack; BranchTaken = s.br;
            Opcode = s.op; Funct = s.fn;
            #1;
            vectors++;
            if (obs() !== s.exp) begin
                miscompares++;
                $display("FAIL branch cyc%0d: got %h want %h",
                         n, obs(), s.exp);
            end
            n++;
            @(negedge CLK);
        end
        MemAck = 0; BranchTaken = 0;
        vectors++;
        if (Retired !== exp_ret || s_Retired !== exp_ret[2:0]) begin
            miscompares++;
            $display("FAIL branch_retired: got %0d/%0d want %0d",
                     Retired, s_Retired, exp_ret);
        end
    endtask

    task automatic test_illegal();
        int n;
        push(0, 1, 0, 6'h3F, 6'h00, V_FACK);
        push(0, 0, 0, 6'h3F, 6'h00, V_ILL);
        push(0, 0, 0, 6'h3F, 6'h00, V_FWAIT);
        n = 0;
        while (sb.size() != 0) begin
            s = sb.pop_front();
            RST = s.rst; MemAck = s.ack; BranchTaken = s.br;
            Opcode = s.op; Funct = s.fn;
            #1;
            vectors++;
            if (obs() !== s.exp) begin
                miscompares++;
                $display("FAIL illegal cyc%0d: got %h want %h",
                         n, obs(), s.exp);
            end
            n++;
            @(negedge CLK);
        end
        MemAck = 0; BranchTaken = 0;
        vectors++;
        if (Retired !== exp_ret) begin
            miscompares++;
            $display("FAIL illegal_retired: got %0d want %0d",
                     Retired, exp_ret);
        end
    endtask

    task automatic test_reset_mid_load();
        int n;
        push(0, 1, 0, 6'h23, 6'h00, V_FACK);
        push(0, 0, 0, 6'h23, 6'h00, V_DEC);
        push(0, 0, 0, 6'h23, 6'h00, V_ADDR);
        push(1, 0, 0, 6'h23, 6'h00, V_MLW);
        push(0, 0, 0, 6'h23, 6'h00, V_FWAIT);
        exp_ret = 0;
        n = 0;
        while (sb.size() != 0) begin
            s = sb.pop_front();
            RST = s.rst; MemAck = s.ack; BranchTaken = s.br;
            Opcode = s.op; Funct = s.fn;
            #1;
            vectors++;
            if (obs() !== s.exp) begin
                miscompares++;
                $display("FAIL midload cyc%0d: got %h want %h",
                         n, obs(), s.exp);
            end
            n++;
            @(negedge CLK);
        end
        MemAck = 0; BranchTaken = 0;
        vectors++;
        if (Retired !== 32'd0 || s_Retired !== 3'd0) begin
            miscompares++;
            $display("FAIL midload_retired: got %0d/%0d want 0",
                     Retired, s_Retired);
        end
    endtask

    task automatic test_wrap();
        int n;
        for (int i = 0; i < 8; i++) begin
            push(0, 1, 0, 6'h02, 6'h00, V_FACK);
            push(0, 0, 0, 6'h02, 6'h00, V_DEC);
            push(0, 0, 0, 6'h02, 6'h00, V_J);
            exp_ret = exp_ret + 1;
            n = 0;
            while (sb.size() != 0) begin
                s = sb.pop_front();
                RST = s.rst; MemAck = s.ack; BranchTaken = s.br;
                Opcode = s.op; Funct = s.fn;
                #1;
                vectors++;
                if (obs() !== s.exp) begin
                    miscompares++;
                    $display("FAIL wrap i%0d cyc%0d: got %h want %h",
                             i, n, obs(), s.exp);
                end
                n++;
                @(negedge CLK);
            end
            MemAck = 0;
            vectors++;
            if (Retired !== exp_ret || s_Retired !== exp_ret[2:0]) begin
                miscompares++;
                $display("FAIL wrap_retired i%0d: got %0d/%0d want %0d/%0d",
                         i, Retired, s_Retired, exp_ret, exp_ret[2:0]);
            end
        end
    endtask

    initial begin
        V_FWAIT = mk(3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0);
        V_FACK  = mk(3'd0, 1, 0, 0, 1, 1, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0);
        V_DEC   = mk(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0);
        V_ILL   = mk(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 1);
        V_EXR   = mk(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0);
        V_EXI   = mk(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd1, 0);
        V_WBR   = mk(3'd3, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 2'd0, 0);
        V_WBI   = mk(3'd3, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd0, 0);
        V_ADDR  = mk(3'd4, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd1, 0);
        V_MLW   = mk(3'd5, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0);
        V_MSW   = mk(3'd5, 1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0);
        V_MWB   = mk(3'd6, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd1, 2'd0, 0);
        V_BR0   = mk(3'd7, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 2'd0, 2'd0, 0);
        V_BR1   = mk(3'd7, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, 2'd0, 0);
        V_JAL   = mk(3'd7, 0, 0, 0, 0, 1, 2'd2, 1, 2'd2, 2'd2, 2'd0, 0);
        V_J     = mk(3'd7, 0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, 2'd0, 0);
        V_JR    = mk(3'd7, 0, 0, 0, 0, 1, 2'd3, 0, 2'd0, 2'd0, 2'd0, 0);

        @(negedge CLK);
        test_reset();
        test_alu();
        test_lw_wait();
        test_sw();
        test_branch_jal();
        test_illegal();
        test_reset_mid_load();
        test_wrap();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
